// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage program counter and IF/ID pipeline register.
// MIPS delay-slot semantics: the instruction after a branch or jump always
// executes. The unit holds on a hazard stall. An illegal next fetch address
// sets a sticky error and freezes the unit.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   stall     hazard unit request: hold PC and IF/ID
//   is_jump   ID-stage branch comparator result (branch taken)
//   n_type    ID-stage next-PC kind: 0 SEQ, 1 BR, 2 J, 3 JR
//   imm16     branch offset in words
//   imm26     jump index
//   rs_val    forwarded register value for JR
//   instr_if  instruction word read from IM at pc_if
//   pc_if     current fetch address
//   instr_id  IF/ID instruction
//   pc_id     IF/ID PC
//   pc8_id    pc_id + 8, link value for jal/jalr
//   valid_id  IF/ID holds a real fetched instruction
//   fetch_err sticky illegal-fetch flag
//   err_pc    offending next-PC captured when the error was raised
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        is_jump,
   input  logic [1:0]  n_type,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_val,
   input  logic [31:0] instr_if,
   output logic [31:0] pc_if,
   output logic [31:0] instr_id,
   output logic [31:0] pc_id,
   output logic [31:0] pc8_id,
   output logic        valid_id,
   output logic        fetch_err,
   output logic [31:0] err_pc
);

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_kind_t;

   // The end bound is 33 bits wide, so a memory that reaches the top of the
   // address space still gives a correct upper-limit compare.
   localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

   npc_kind_t   kind;
   logic [31:0] seq_pc;
   logic [31:0] br_off;
   logic [31:0] npc;
   logic        npc_bad;

   assign kind   = npc_kind_t'(n_type);
   assign seq_pc = pc_if + 32'd4;
   assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
   assign pc8_id = pc_id + 32'd8;

   // The ID inputs are meaningful only when IF/ID holds a real instruction.
   // Branch and jump targets are relative to pc_id, not to the delay slot.
   always_comb begin
      npc = seq_pc;
      if (valid_id) begin
         unique case (kind)
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = is_jump ? (pc_id + 32'd4 + br_off) : seq_pc;
            NPC_J:   npc = {pc_id[31:28], imm26, 2'b00};
            NPC_JR:  npc = rs_val;
         endcase
      end
   end

   assign npc_bad = (npc[1:0] != 2'b00) || (npc < IM_BASE) ||
                    ({1'b0, npc} >= IM_END);

   // Stall has priority over the legality check: npc is neither used nor
   // checked while stalled, because the ID operands may be stale.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_if     <= RESET_PC;
         instr_id  <= '0;
         pc_id     <= '0;
         valid_id  <= 1'b0;
         fetch_err <= 1'b0;
         err_pc    <= '0;
      end else if (!stall && !fetch_err) begin
         pc_id <= pc_if;
         if (npc_bad) begin
            fetch_err <= 1'b1;
            err_pc    <= npc;
            instr_id  <= '0;
            valid_id  <= 1'b0;
         end else begin
            pc_if    <= npc;
            instr_id <= instr_if;
            valid_id <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed steps followed by a randomized run,
// checked against a behavioural model of the fetch unit.
module tb_fetch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] BASE   = 32'h0000_3000;
   localparam int unsigned WORDS  = 4096;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        is_jump;
   logic [1:0]  n_type;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] rs_val;
   logic [31:0] instr_if;
   logic [31:0] pc_if;
   logic [31:0] instr_id;
   logic [31:0] pc_id;
   logic [31:0] pc8_id;
   logic        valid_id;
   logic        fetch_err;
   logic [31:0] err_pc;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Model state
   logic [31:0] m_pc, m_instr, m_pcid, m_errpc;
   logic        m_valid, m_err;

   fetch_pc_unit #(.RESET_PC(RST_PC), .IM_BASE(BASE), .IM_WORDS(WORDS)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .is_jump(is_jump),
      .n_type(n_type), .imm16(imm16), .imm26(imm26), .rs_val(rs_val),
      .instr_if(instr_if), .pc_if(pc_if), .instr_id(instr_id), .pc_id(pc_id),
      .pc8_id(pc8_id), .valid_id(valid_id), .fetch_err(fetch_err),
      .err_pc(err_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_npc();
      longint off;
      if (!m_valid) return m_pc + 32'd4;
      case (n_type)
         2'd1: begin
            if (!is_jump) return m_pc + 32'd4;
            off = longint'($signed(imm16)) * 4;
            return 32'((longint'(m_pcid) + 4 + off) % (longint'(1) << 32));
         end
         2'd2:    return (m_pcid & 32'hF000_0000) | (32'(imm26) * 4);
         2'd3:    return rs_val;
         default: return m_pc + 32'd4;
      endcase
   endfunction

   function automatic bit model_legal(input logic [31:0] a);
      longint lim;
      lim = longint'(BASE) + 4 * longint'(WORDS);
      return (a % 4 == 0) && (longint'(a) >= longint'(BASE)) && (longint'(a) < lim);
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_instr = 0; m_pcid = 0; m_valid = 0; m_err = 0; m_errpc = 0;
   endtask

   task automatic model_edge();
      logic [31:0] n;
      if (reset_n && !stall && !m_err) begin
         n = model_npc();
         m_pcid = m_pc;
         if (model_legal(n)) begin
            m_pc = n; m_instr = instr_if; m_valid = 1;
         end else begin
            m_err = 1; m_errpc = n; m_instr = 0; m_valid = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc_if"},     pc_if,     m_pc);
      check({tag, ".instr_id"},  instr_id,  m_instr);
      check({tag, ".pc_id"},     pc_id,     m_pcid);
      check({tag, ".pc8_id"},    pc8_id,    m_pcid + 32'd8);
      check({tag, ".valid_id"},  32'(valid_id),  32'(m_valid));
      check({tag, ".fetch_err"}, 32'(fetch_err), 32'(m_err));
      check({tag, ".err_pc"},    err_pc,    m_errpc);
   endtask

   // One clock edge; outputs sampled 1 time unit after it.
   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between edges.
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".rst"});
      #1;
      reset_n = 1'b1;
   endtask

   task automatic seq_inputs(input logic [31:0] instr);
      stall = 0; is_jump = 0; n_type = 2'd0; imm16 = 0; imm26 = 0; rs_val = 0;
      instr_if = instr;
   endtask

   initial begin
      reset_n = 1'b1;
      seq_inputs(32'h0);
      model_reset();
      #2;
      do_reset("t1");
      check("t1.reset_pc", pc_if, 32'h0000_3000);

      // 1: sequential fetch
      seq_inputs(32'h1111_1111);
      tick("t1.e1");
      check("t1.e1.pc_if", pc_if, 32'h0000_3004);
      check("t1.e1.valid", 32'(valid_id), 32'd1);
      tick("t1.e2");
      tick("t1.e3");
      check("t1.e3.pc_if", pc_if, 32'h0000_300C);
      check("t1.e3.pc_id", pc_id, 32'h0000_3008);
      check("t1.e3.instr", instr_id, 32'h1111_1111);
      check("t1.e3.pc8", pc8_id, 32'h0000_3010);

      // 2: branch taken backwards, delay slot enters ID
      n_type = 2'd1; imm16 = 16'hFFFE; is_jump = 1; instr_if = 32'h2222_2222;
      tick("t2.taken");
      check("t2.taken.pc_if", pc_if, 32'h0000_3004);
      check("t2.taken.slot", instr_id, 32'h2222_2222);
      check("t2.taken.pc_id", pc_id, 32'h0000_300C);

      // 2b: branch not taken from the same starting state
      do_reset("t2b");
      seq_inputs(32'h1111_1111);
      repeat (3) tick("t2b.seq");
      n_type = 2'd1; imm16 = 16'hFFFE; is_jump = 0; instr_if = 32'h3333_3333;
      tick("t2b.nt");
      check("t2b.nt.pc_if", pc_if, 32'h0000_3010);

      // 3: J relative to pc_id region, then JR
      seq_inputs(32'h4444_4444);
      tick("t3.seq");
      check("t3.seq.pc_id", pc_id, 32'h0000_3010);
      n_type = 2'd2; imm26 = 26'h000_0C10;
      tick("t3.j");
      check("t3.j.pc_if", pc_if, 32'h0000_3040);
      n_type = 2'd3; rs_val = 32'h0000_3100;
      tick("t3.jr");
      check("t3.jr.pc_if", pc_if, 32'h0000_3100);

      // 4: stall with a branch in ID; operands ignored while stalled
      n_type = 2'd1; imm16 = 16'h0004; is_jump = 0; stall = 1; instr_if = 32'h5555_5555;
      tick("t4.st1");
      is_jump = 1;
      tick("t4.st2");
      check("t4.st2.pc_if", pc_if, 32'h0000_3100);
      check("t4.st2.pc_id", pc_id, 32'h0000_3040);
      check("t4.st2.instr", instr_id, 32'h4444_4444);
      stall = 0;
      tick("t4.rel");
      check("t4.rel.pc_if", pc_if, 32'h0000_3054);
      seq_inputs(32'h6666_6666);
      tick("t4.after");
      check("t4.after.pc_if", pc_if, 32'h0000_3058);

      // 5: misaligned JR target
      n_type = 2'd3; rs_val = 32'h0000_3102;
      tick("t5.err");
      check("t5.err.flag", 32'(fetch_err), 32'd1);
      check("t5.err.pc", err_pc, 32'h0000_3102);
      check("t5.err.pc_if", pc_if, 32'h0000_3058);
      check("t5.err.valid", 32'(valid_id), 32'd0);
      for (int i = 0; i < 5; i++) begin
         stall = 1'($urandom); is_jump = 1'($urandom); n_type = 2'($urandom);
         rs_val = $urandom; imm16 = 16'($urandom); instr_if = $urandom;
         tick("t5.frozen");
      end

      // 5b: out of range target; stall masks it first
      do_reset("t5b");
      seq_inputs(32'h7777_7777);
      tick("t5b.seq");
      n_type = 2'd3; rs_val = 32'h0000_7000; stall = 1;
      tick("t5b.stall_masks");
      check("t5b.stall_masks.flag", 32'(fetch_err), 32'd0);
      stall = 0;
      tick("t5b.err");
      check("t5b.err.pc", err_pc, 32'h0000_7000);
      check("t5b.err.flag", 32'(fetch_err), 32'd1);

      // 6: async reset mid-cycle during stall with error set
      stall = 1;
      tick("t6.frozen");
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all("t6.async");
      check("t6.async.pc_if", pc_if, 32'h0000_3000);
      check("t6.async.err", 32'(fetch_err), 32'd0);
      #1;
      reset_n = 1'b1;
      seq_inputs(32'h8888_8888);
      tick("t6.resume");
      check("t6.resume.pc_id", pc_id, 32'h0000_3000);
      check("t6.resume.pc_if", pc_if, 32'h0000_3004);

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         stall    = ($urandom_range(0, 3) == 0);
         is_jump  = 1'($urandom);
         n_type   = 2'($urandom);
         imm16    = 16'($signed(12'($urandom)));
         imm26    = 26'(32'h0000_0C00 + $urandom_range(0, 4095));
         rs_val   = ($urandom_range(0, 15) == 0) ? $urandom
                                                 : BASE + 4 * $urandom_range(0, WORDS - 1);
         instr_if = $urandom;
         tick("rnd");
         if (m_err && $urandom_range(0, 3) == 0) do_reset("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage program counter plus IF/ID pipeline register.
- Sits directly downstream of the ID-stage branch comparator: consumes its taken flag (is_jump) together with the ID-stage next-PC type and immediates, and computes the next fetch address.
- MIPS delay-slot semantics: the instruction after a branch or jump always executes.
- Holds on hazard stall and freezes with a sticky error on an illegal fetch address.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, lowest legal instruction address
IM_WORDS, 4096, instruction memory depth in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit request: hold PC and IF/ID
is_jump  input  1  ID-stage comparator result, branch taken
n_type  input  2  ID-stage next-PC kind: 0 SEQ, 1 BR, 2 J (j/jal), 3 JR
imm16  input  16  ID-stage branch offset, in words
imm26  input  26  ID-stage jump index
rs_val  input  32  ID-stage forwarded register value for JR
instr_if  input  32  instruction word read from IM at pc_if
pc_if  output  32  current fetch address to IM
instr_id  output  32  IF/ID instruction
pc_id  output  32  IF/ID PC
pc8_id  output  32  pc_id+8, jal/jalr link value
valid_id  output  1  IF/ID holds a real fetched instruction
fetch_err  output  1  sticky illegal-fetch flag
err_pc  output  32  offending next-PC captured at error

Behaviour:
- Reset (reset_n low, async, any time): pc_if=RESET_PC, instr_id=0 (nop), pc_id=0, valid_id=0, fetch_err=0, err_pc=0. Reset mid-stall or mid-error clears everything immediately.
- npc selection, combinational, evaluated only when valid_id=1. When valid_id=0, npc=pc_if+4.
  - SEQ, or BR with is_jump=0: pc_if+4.
  - BR with is_jump=1: pc_id+4+(sign_extend(imm16)<<2).
  - J: {pc_id[31:28], imm26, 2'b00}, i.e. the region of pc_id, not of the delay slot.
  - JR: rs_val.
- All adds are 32-bit modulo 2^32; the carry is dropped, so 32'hFFFF_FFFC+4 gives 0.
- Rising clk, stall=0, fetch_err=0: pc_if<=npc; instr_id<=instr_if; pc_id<=pc_if; valid_id<=1.
- Delay slot: when a branch or jump is in ID, IF already holds pc_id+4. That instruction enters ID on the same edge that loads the target. No flush, no bubble.
- One-cycle redirect latency: pc_if shows the target on the edge after the branch's ID cycle.
- Rising clk, stall=1: pc_if, instr_id, pc_id and valid_id hold.
  - is_jump, n_type and rs_val are ignored, since operands may be stale.
  - The redirect happens on the first non-stalled edge, using the then-current ID inputs.
- Illegal npc: npc[1:0]!=0, or npc<IM_BASE, or npc>=IM_BASE+4*IM_WORDS. Checked only on an edge where an update would occur (stall=0, fetch_err=0). On that edge:
  - fetch_err<=1 and err_pc<=npc.
  - pc_if holds its old value.
  - instr_id<=0, valid_id<=0.
  - pc_id<=pc_if, as normal.
- fetch_err set: the unit is frozen.
  - All registers hold and further npc values are ignored.
  - stall has no effect.
  - Only reset_n clears the flag.
- Simultaneous stall=1 and an illegal npc: stall wins. No error is raised on that edge.
- pc8_id = pc_id+8, combinational, 32-bit wrap.
- No internal state beyond the registers listed above.

Test Plan:
1. Reset, then 3 edges with n_type=0 and instr_if=32'h1111_1111 -> pc_if 3000, 3004, 3008, 300C; pc_id=3008 and instr_id=1111_1111 after the 3rd edge; valid_id=1 from the 1st edge; pc8_id=3010.
2. BR taken: pc_id=3008, imm16=16'hFFFE, is_jump=1, one edge -> pc_if=3004 (3008+4-8); instr_id=delay slot fetched from 300C. Repeat with is_jump=0 -> pc_if=3010.
3. J with pc_id=3010, imm26=26'h0000C10 -> pc_if=3040. JR with rs_val=32'h0000_3100 -> pc_if=3100.
4. Stall: branch in ID, stall=1 for 2 edges with is_jump toggling -> pc_if, pc_id and instr_id unchanged. Release stall with is_jump=1 -> redirect occurs exactly once, to the target.
5. Errors:
   - JR with rs_val=32'h0000_3102 -> fetch_err=1, err_pc=3102, pc_if unchanged, valid_id=0, registers frozen for 5 edges.
   - rs_val=32'h0000_7000 (out of range) gives the same result with err_pc=7000.
6. reset_n pulsed low mid-cycle, between edges, during a stall with fetch_err=1 -> outputs return to reset values immediately, before the next clk edge; fetch resumes from 3000.
